// File: rtl/div_iter_pkg.sv
// Shared constants for the iterative divider: FSM state codes and handshake levels.
package div_iter_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_iter_if.sv
// EX <-> divider handshake: EX is the master, the divider is the slave.
interface div_iter_if #(
  parameter int WIDTH = div_iter_pkg::DIV_WIDTH
);

  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on operand
// magnitudes, signs restored on the final step. Returns {remainder, quotient}.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  div_iter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] val, input logic en);
    cond_neg = en ? (~val + {{(WIDTH-1){1'b0}}, 1'b1}) : val;
  endfunction

  div_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   dividend_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quot_q;
  logic               signed_q;
  logic               sign1_q;
  logic               sign2_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  // The partial remainder keeps one extra bit so divisors with the msb set cannot overflow it.
  logic [WIDTH:0]     partial_d;
  logic [WIDTH:0]     diff_d;
  logic               q_bit_d;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quot_d;
  logic [WIDTH-1:0]   rem_fix_d;
  logic [WIDTH-1:0]   quot_fix_d;

  assign partial_d  = {rem_q, dividend_q[WIDTH-1]};
  assign diff_d     = partial_d - {1'b0, divisor_q};
  assign q_bit_d    = ~diff_d[WIDTH];
  assign rem_d      = q_bit_d ? diff_d[WIDTH-1:0] : partial_d[WIDTH-1:0];
  assign quot_d     = {quot_q[WIDTH-2:0], q_bit_d};
  // Remainder follows the dividend's sign; quotient is negative when the signs differ.
  assign quot_fix_d = cond_neg(quot_d, signed_q & (sign1_q ^ sign2_q));
  assign rem_fix_d  = cond_neg(rem_d, signed_q & sign1_q);

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

  // Divider FSM: operand capture, iteration, sign fix-up and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= {CNT_W{1'b0}};
      dividend_q <= {WIDTH{1'b0}};
      divisor_q  <= {WIDTH{1'b0}};
      rem_q      <= {WIDTH{1'b0}};
      quot_q     <= {WIDTH{1'b0}};
      signed_q   <= 1'b0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      result_q   <= {(2*WIDTH){1'b0}};
      ready_q    <= DivResultNotReady;
    end else begin
      case (state_q)
        DivFree: begin
          ready_q  <= DivResultNotReady;
          result_q <= {(2*WIDTH){1'b0}};
          if (bus.start_i == DivStart && bus.annul_i == 1'b0) begin
            if (bus.opdata2_i == {WIDTH{1'b0}}) begin
              state_q <= DivByZero;
            end else begin
              dividend_q <= cond_neg(bus.opdata1_i, bus.signed_div_i & bus.opdata1_i[WIDTH-1]);
              divisor_q  <= cond_neg(bus.opdata2_i, bus.signed_div_i & bus.opdata2_i[WIDTH-1]);
              signed_q   <= bus.signed_div_i;
              sign1_q    <= bus.opdata1_i[WIDTH-1];
              sign2_q    <= bus.opdata2_i[WIDTH-1];
              rem_q      <= {WIDTH{1'b0}};
              quot_q     <= {WIDTH{1'b0}};
              cnt_q      <= {CNT_W{1'b0}};
              state_q    <= DivOn;
            end
          end else begin
            state_q <= DivFree;
          end
        end
        DivByZero: begin
          result_q <= {(2*WIDTH){1'b0}};
          ready_q  <= DivResultReady;
          state_q  <= DivEnd;
        end
        DivOn: begin
          if (bus.annul_i == 1'b1) begin
            ready_q  <= DivResultNotReady;
            result_q <= {(2*WIDTH){1'b0}};
            state_q  <= DivFree;
          end else begin
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dividend_q <= {dividend_q[WIDTH-2:0], 1'b0};
            cnt_q      <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              result_q <= {rem_fix_d, quot_fix_d};
              ready_q  <= DivResultReady;
              state_q  <= DivEnd;
            end else begin
              state_q <= DivOn;
            end
          end
        end
        DivEnd: begin
          ready_q  <= DivResultNotReady;
          result_q <= {(2*WIDTH){1'b0}};
          state_q  <= DivFree;
        end
        default: begin
          ready_q  <= DivResultNotReady;
          result_q <= {(2*WIDTH){1'b0}};
          state_q  <= DivFree;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed testbench for div_iter: latency, signed/unsigned results, divide-by-zero,
// annul, async reset and restart while start is held.
module tb_div_iter;
  import div_iter_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  div_iter_if #(.WIDTH(W)) bus ();

  div_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic wait_ready(input int max_edges, output int edges, output bit seen);
    seen  = 1'b0;
    edges = 0;
    while (!seen && edges < max_edges) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (bus.ready_o === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic run_op(input string name, input logic sdiv, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp, input int exp_edges);
    int edges;
    bit seen;
    @(negedge clk);
    bus.signed_div_i = sdiv;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = DivStart;
    @(posedge clk);
    #1;
    bus.opdata1_i    = ~a;
    bus.opdata2_i    = ~b;
    bus.signed_div_i = ~sdiv;
    wait_ready(40, edges, seen);
    n_checks++;
    if (!seen || edges != exp_edges) begin
      n_fail++;
      $display("FAIL %s latency: got edges=%0d seen=%0b, want edges=%0d", name, edges, seen, exp_edges);
    end
    n_checks++;
    if (bus.result_o !== exp) begin
      n_fail++;
      $display("FAIL %s result: got %h, want %h", name, bus.result_o, exp);
    end
    bus.start_i = DivStop;
    @(negedge clk);
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== {(2*W){1'b0}}) begin
      n_fail++;
      $display("FAIL %s pulse: got ready=%b result=%h, want 0/0", name, bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = DivStop;
    bus.annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, want 0", bus.ready_o);
    end
    n_checks++;
    if (bus.result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %h, want 0", bus.result_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    run_op("divu_7_2",      1'b0, 32'd7,          32'd2,          64'h00000001_00000003, 32);
    run_op("divu_ffff_1",   1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 32);
    run_op("divu_5_9",      1'b0, 32'd5,          32'd9,          64'h00000005_00000000, 32);
    run_op("divu_big_div",  1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   64'h00000001_00000001, 32);
  endtask

  task automatic test_signed();
    run_op("div_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 32);
    run_op("div_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 32);
    run_op("div_m7_m2",     1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 32);
    run_op("div_overflow",  1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 32);
  endtask

  task automatic test_byzero();
    run_op("divu_by_zero",  1'b0, 32'd5,          32'd0,          64'd0, 1);
    run_op("div_by_zero",   1'b1, 32'hFFFFFFFB,   32'd0,          64'd0, 1);
  endtask

  task automatic test_annul();
    int edges;
    bit seen;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = DivStart;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = DivStop;
    @(negedge clk);
    bus.annul_i = 1'b0;
    wait_ready(40, edges, seen);
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL annul_no_ready: got ready after %0d edges, want none", edges);
    end
    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 32);
    // start and annul together must not be accepted
    @(negedge clk);
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd4;
    bus.start_i   = DivStart;
    bus.annul_i   = 1'b1;
    repeat (2) @(negedge clk);
    bus.start_i = DivStop;
    bus.annul_i = 1'b0;
    wait_ready(40, edges, seen);
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL start_annul_same: got ready after %0d edges, want none", edges);
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    bit seen;
    logic [2*W-1:0] exp_q[$];
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd7;
    bus.opdata2_i    = 32'd2;
    bus.start_i      = DivStart;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_mid_op: got ready=%b result=%h, want 0/0", bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(64'h00000001_00000003);
    exp_q.push_back(64'h00000001_00000003);
    @(posedge clk);
    wait_ready(40, edges, seen);
    n_checks++;
    if (!seen || edges != 32 || bus.result_o !== exp_q[0]) begin
      n_fail++;
      $display("FAIL rst_recover: got seen=%0b edges=%0d result=%h, want 32 edges result %h",
               seen, edges, bus.result_o, exp_q[0]);
    end
    void'(exp_q.pop_front());
    // start stays high: END -> FREE -> accept -> 32 steps
    wait_ready(40, edges, seen);
    n_checks++;
    if (!seen || edges != 34 || bus.result_o !== exp_q[0]) begin
      n_fail++;
      $display("FAIL held_restart: got seen=%0b edges=%0d result=%h, want 34 edges result %h",
               seen, edges, bus.result_o, exp_q[0]);
    end
    void'(exp_q.pop_front());
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_during_ready: got ready=%b result=%h, want 0/0", bus.ready_o, bus.result_o);
    end
    bus.start_i = DivStop;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_byzero();
    test_annul();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
